// File: rtl/tsi_pkg.sv
// Shared definitions for the chip-side TSI endpoint.
//   TSI_WORD_W    : width of one TSI link word
//   TSI_CMD_*     : legal values of the command word
//   tsi_state_e   : state encoding of the target FSM
package tsi_pkg;

    localparam int TSI_WORD_W = 32;

    localparam logic [TSI_WORD_W-1:0] TSI_CMD_READ  = 32'd0;
    localparam logic [TSI_WORD_W-1:0] TSI_CMD_WRITE = 32'd1;

    typedef enum logic [3:0] {
        S_CMD,
        S_ADDR_LO,
        S_ADDR_HI,
        S_LEN_LO,
        S_LEN_HI,
        S_WR_DATA,
        S_WR_REQ,
        S_WR_ACK,
        S_RD_REQ,
        S_RD_RESP,
        S_RD_SEND
    } tsi_state_e;

endpackage

// File: rtl/tsi_target.sv
// TSI target: parses the host command stream (cmd, addr_lo, addr_hi,
// len_lo, len_hi, [write data]) and turns it into single-word memory
// requests, returning read data to the host.
// Ports:
//   clock, reset                 : clock, async active-high reset
//   tsi_in_valid/ready/bits      : host -> chip word stream
//   tsi_out_valid/ready/bits     : chip -> host word stream (read data)
//   mem_req_valid/ready          : memory request handshake
//   mem_req_write/addr/wdata     : memory request payload
//   mem_resp_valid/data          : memory response (read data or write ack)
//   busy                         : FSM is not waiting for a command
//   err                          : sticky illegal-command flag
module tsi_target
    import tsi_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tsi_in_valid,
    output logic                  tsi_in_ready,
    input  logic [TSI_WORD_W-1:0] tsi_in_bits,
    output logic                  tsi_out_valid,
    input  logic                  tsi_out_ready,
    output logic [TSI_WORD_W-1:0] tsi_out_bits,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic [TSI_WORD_W-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [TSI_WORD_W-1:0] mem_resp_data,
    output logic                  busy,
    output logic                  err
);

    tsi_state_e            state;
    logic                  is_write;
    logic [ADDR_W-1:0]     addr;
    logic [TSI_WORD_W-1:0] count;
    logic [TSI_WORD_W-1:0] data;
    logic                  err_q;

    // Everything the outside world sees is decoded from registers only,
    // so no combinational path exists from any input to any output.
    assign tsi_in_ready  = (state == S_CMD)     || (state == S_ADDR_LO) ||
                           (state == S_ADDR_HI) || (state == S_LEN_LO)  ||
                           (state == S_LEN_HI)  || (state == S_WR_DATA);
    assign mem_req_valid = (state == S_WR_REQ) || (state == S_RD_REQ);
    assign mem_req_write = (state == S_WR_REQ);
    assign mem_req_addr  = addr;
    assign mem_req_wdata = data;
    assign tsi_out_valid = (state == S_RD_SEND);
    assign tsi_out_bits  = data;
    assign busy          = (state != S_CMD);
    assign err           = err_q;

    // Single FSM. count holds "words remaining minus one", so a burst ends
    // when a word completes with count==0; 0xFFFFFFFF therefore runs for the
    // full 2^32 words. The same data register serves as write data and as
    // captured read data, keeping tsi_out_bits stable while the host stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_CMD;
            is_write <= 1'b0;
            addr     <= '0;
            count    <= '0;
            data     <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_CMD: if (tsi_in_valid) begin
                    if (tsi_in_bits == TSI_CMD_READ || tsi_in_bits == TSI_CMD_WRITE) begin
                        is_write <= (tsi_in_bits == TSI_CMD_WRITE);
                        state    <= S_ADDR_LO;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                S_ADDR_LO: if (tsi_in_valid) begin
                    addr  <= ADDR_W'(tsi_in_bits);
                    state <= S_ADDR_HI;
                end
                // Only the low ADDR_W bits of the 64-bit address are kept.
                S_ADDR_HI: if (tsi_in_valid) begin
                    addr  <= ADDR_W'({tsi_in_bits, 32'(addr)});
                    state <= S_LEN_LO;
                end
                S_LEN_LO: if (tsi_in_valid) begin
                    count <= tsi_in_bits;
                    state <= S_LEN_HI;
                end
                // The upper length word carries no information for a 32-bit count.
                S_LEN_HI: if (tsi_in_valid) begin
                    state <= is_write ? S_WR_DATA : S_RD_REQ;
                end
                S_WR_DATA: if (tsi_in_valid) begin
                    data  <= tsi_in_bits;
                    state <= S_WR_REQ;
                end
                S_WR_REQ: if (mem_req_ready) begin
                    state <= S_WR_ACK;
                end
                S_WR_ACK: if (mem_resp_valid) begin
                    if (count == '0) begin
                        state <= S_CMD;
                    end else begin
                        count <= count - 32'd1;
                        addr  <= addr + ADDR_W'(WORD_BYTES);
                        state <= S_WR_DATA;
                    end
                end
                S_RD_REQ: if (mem_req_ready) begin
                    state <= S_RD_RESP;
                end
                S_RD_RESP: if (mem_resp_valid) begin
                    data  <= mem_resp_data;
                    state <= S_RD_SEND;
                end
                S_RD_SEND: if (tsi_out_ready) begin
                    if (count == '0) begin
                        state <= S_CMD;
                    end else begin
                        count <= count - 32'd1;
                        addr  <= addr + ADDR_W'(WORD_BYTES);
                        state <= S_RD_REQ;
                    end
                end
                default: state <= S_CMD;
            endcase
        end
    end

endmodule

// File: tb/tb_tsi_target.sv
// Testbench for tsi_target: a host driver issues directed and random
// READ/WRITE commands while a memory responder with random ready/latency
// serves requests. Expected request streams and read data are derived
// from the command parameters (base address, length, data).
module tb_tsi_target;
    import tsi_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        tsi_in_valid = 1'b0;
    logic        tsi_in_ready;
    logic [31:0] tsi_in_bits = '0;
    logic        tsi_out_valid;
    logic        tsi_out_ready = 1'b0;
    logic [31:0] tsi_out_bits;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_write;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        busy;
    logic        err;

    int vec_count  = 0;
    int miss_count = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_q[$];
    logic        hold_resp   = 1'b0;
    logic        outstanding = 1'b0;
    int          resp_wait   = 0;
    logic [31:0] resp_word   = '0;
    logic        stalled     = 1'b0;
    logic        last_wr     = 1'b0;
    logic [31:0] last_addr   = '0;
    logic [31:0] last_wdata  = '0;

    tsi_target #(.ADDR_W(32), .WORD_BYTES(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .tsi_in_valid  (tsi_in_valid),
        .tsi_in_ready  (tsi_in_ready),
        .tsi_in_bits   (tsi_in_bits),
        .tsi_out_valid (tsi_out_valid),
        .tsi_out_ready (tsi_out_ready),
        .tsi_out_bits  (tsi_out_bits),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_write (mem_req_write),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .busy          (busy),
        .err           (err)
    );

    always #5 clock = ~clock;

    // Content of the simulated memory: a fixed function of the byte address.
    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            miss_count++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Memory responder: random ready, 0..2 cycle response latency, and
    // checking of every request against the expected request queue.
    always @(negedge clock) begin
        if (reset) begin
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            outstanding    = 1'b0;
            stalled        = 1'b0;
        end else begin
            mem_resp_valid = 1'b0;
            if (mem_req_valid) begin
                check("req_while_word_pending", 32'(outstanding || tsi_out_valid), 32'd0);
                if (stalled) begin
                    check("req_stable_wr",    32'(mem_req_write), 32'(last_wr));
                    check("req_stable_addr",  mem_req_addr,  last_addr);
                    check("req_stable_wdata", mem_req_wdata, last_wdata);
                end
            end
            if (outstanding && !hold_resp) begin
                if (resp_wait == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = resp_word;
                    outstanding    = 1'b0;
                end else begin
                    resp_wait--;
                end
            end
            if (mem_req_valid && !outstanding) begin
                mem_req_ready = ($urandom_range(0, 2) != 0);
                if (mem_req_ready) begin
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_req", 32'd1, 32'd0);
                    end else begin
                        req_t e;
                        e = exp_q.pop_front();
                        check("req_write", 32'(mem_req_write), 32'(e.wr));
                        check("req_addr",  mem_req_addr, e.addr);
                        if (e.wr) check("req_wdata", mem_req_wdata, e.wdata);
                    end
                    outstanding = 1'b1;
                    resp_wait   = $urandom_range(0, 2);
                    resp_word   = mem_req_write ? 32'd0 : rd_fn(mem_req_addr);
                end else begin
                    stalled    = 1'b1;
                    last_wr    = mem_req_write;
                    last_addr  = mem_req_addr;
                    last_wdata = mem_req_wdata;
                end
            end else begin
                mem_req_ready = 1'b0;
                stalled       = 1'b0;
            end
        end
    end

    // Host side: all tasks start and end just after a falling edge.
    task automatic send_word(input logic [31:0] w, input string tag);
        int n = 0;
        tsi_in_valid = 1'b1;
        tsi_in_bits  = w;
        while (!tsi_in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_in_timeout"}, 32'(n >= 200), 32'd0);
        @(posedge clock);
        @(negedge clock);
        tsi_in_valid = 1'b0;
    endtask

    task automatic recv_word(input logic [31:0] exp, input string tag, input int stall);
        int n = 0;
        logic [31:0] held;
        while (!tsi_out_valid && n < 400) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_out_timeout"}, 32'(n >= 400), 32'd0);
        held = tsi_out_bits;
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            check({tag, "_stall_valid"}, 32'(tsi_out_valid), 32'd1);
            check({tag, "_stall_bits"}, tsi_out_bits, held);
        end
        check(tag, tsi_out_bits, exp);
        tsi_out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        tsi_out_ready = 1'b0;
    endtask

    task automatic send_header(input logic [31:0] cmd, input logic [31:0] alo,
                               input logic [31:0] ahi, input logic [31:0] len);
        send_word(cmd, "cmd");
        send_word(alo, "addr_lo");
        send_word(ahi, "addr_hi");
        send_word(len, "len_lo");
        send_word($urandom, "len_hi");
    endtask

    task automatic do_write(input logic [31:0] alo, input logic [31:0] ahi,
                            input int len, input logic [31:0] first, input string tag);
        logic [31:0] d[$];
        int n = 0;
        logic out_seen = 1'b0;
        for (int i = 0; i <= len; i++) begin
            req_t e;
            d.push_back(i == 0 ? first : $urandom);
            e.wr = 1'b1;
            e.addr = alo + 32'(4 * i);
            e.wdata = d[i];
            exp_q.push_back(e);
        end
        send_header(TSI_CMD_WRITE, alo, ahi, 32'(len));
        for (int i = 0; i <= len; i++) begin
            if (tsi_out_valid) out_seen = 1'b1;
            send_word(d[i], "wdata");
        end
        while (busy && n < 400) begin
            if (tsi_out_valid) out_seen = 1'b1;
            @(negedge clock);
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(n >= 400), 32'd0);
        check({tag, "_no_out"}, 32'(out_seen), 32'd0);
        check({tag, "_all_reqs"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] alo, input int len, input int stall0, input string tag);
        for (int i = 0; i <= len; i++) begin
            req_t e;
            e.wr = 1'b0;
            e.addr = alo + 32'(4 * i);
            e.wdata = '0;
            exp_q.push_back(e);
        end
        send_header(TSI_CMD_READ, alo, $urandom, 32'(len));
        for (int i = 0; i <= len; i++) begin
            recv_word(rd_fn(alo + 32'(4 * i)), {tag, "_data"}, (i == 0) ? stall0 : 0);
        end
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_all_reqs"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        #1 reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("rst_busy",       32'(busy), 32'd0);
        check("rst_err",        32'(err), 32'd0);
        check("rst_in_ready",   32'(tsi_in_ready), 32'd1);
        check("rst_out_valid",  32'(tsi_out_valid), 32'd0);
        check("rst_req_valid",  32'(mem_req_valid), 32'd0);
        check("rst_req_addr",   mem_req_addr, 32'd0);
        check("rst_req_wdata",  mem_req_wdata, 32'd0);
        check("rst_out_bits",   tsi_out_bits, 32'd0);
        #2 reset = 1'b0;
        @(negedge clock);

        do_write(32'h8000_0000, 32'h0, 0, 32'hDEAD_BEEF, "wr_single");
        do_read(32'h0000_1000, 3, 0, "rd_four");
        do_read(32'h0000_2000, 1, 5, "rd_backpressure");
        do_write(32'hFFFF_FFFC, 32'h1, 1, $urandom, "wr_wrap");

        send_word(32'd7, "illegal_cmd");
        check("illegal_err",  32'(err), 32'd1);
        check("illegal_busy", 32'(busy), 32'd0);
        do_read(32'h0000_0040, 0, 0, "rd_after_err");
        check("err_sticky", 32'(err), 32'd1);

        for (int t = 0; t < 6; t++) begin
            logic [31:0] a;
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom, $urandom_range(0, 3), $urandom, "wr_rand");
            else                           do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), "rd_rand");
        end

        // Abort a write burst while the first word awaits its ack.
        begin
            req_t e;
            e.wr = 1'b1;
            e.addr = 32'h0000_3000;
            e.wdata = 32'h1234_5678;
            exp_q.push_back(e);
        end
        hold_resp = 1'b1;
        send_header(TSI_CMD_WRITE, 32'h0000_3000, 32'h0, 32'd3);
        send_word(32'h1234_5678, "abort_wdata");
        n = 0;
        while (!outstanding && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("abort_req_timeout", 32'(n >= 100), 32'd0);
        check("abort_in_ack",      32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_req_valid", 32'(mem_req_valid), 32'd0);
        check("abort_req_write", 32'(mem_req_write), 32'd0);
        check("abort_req_addr",  mem_req_addr, 32'd0);
        check("abort_req_wdata", mem_req_wdata, 32'd0);
        check("abort_out_valid", 32'(tsi_out_valid), 32'd0);
        check("abort_out_bits",  tsi_out_bits, 32'd0);
        check("abort_busy",      32'(busy), 32'd0);
        check("abort_err",       32'(err), 32'd0);
        check("abort_in_ready",  32'(tsi_in_ready), 32'd1);
        check("abort_issued",    32'(exp_q.size()), 32'd0);
        @(negedge clock);
        @(negedge clock);
        hold_resp = 1'b0;
        #2 reset = 1'b0;
        @(negedge clock);
        do_read(32'h0000_5000, 2, 1, "rd_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/tsi_target.md
Name: tsi_target

Overview:
- Chip-side endpoint of the 32-bit TSI serial link; the simulation host driver is the initiator at the other end.
- Parses the host command stream (READ/WRITE with address and length) and turns it into single-word memory requests on a simple valid/ready port.
- On READ, streams the read data back to the host.
- Sits between the TSI pins/serdes and the on-chip memory or bus bridge.

Parameters:
- ADDR_W, 32: width of memory address driven on mem_req_addr. Low ADDR_W bits of the 64-bit TSI address are used; the rest are discarded.
- WORD_BYTES, 4: address increment per transferred word.

Ports:
- clock  input  1  sole clock
- reset  input  1  asynchronous, active-high reset
- tsi_in_valid  input  1  host→chip word valid
- tsi_in_ready  output  1  chip accepts host word
- tsi_in_bits  input  32  host→chip word
- tsi_out_valid  output  1  chip→host word valid
- tsi_out_ready  input  1  host accepts chip word
- tsi_out_bits  output  32  chip→host word
- mem_req_valid  output  1  memory request valid
- mem_req_ready  input  1  memory accepts request
- mem_req_write  output  1  1=write, 0=read
- mem_req_addr  output  ADDR_W  word address (byte address, WORD_BYTES aligned as given by host)
- mem_req_wdata  output  32  write data
- mem_resp_valid  input  1  response (read data or write ack); always accepted
- mem_resp_data  input  32  read data
- busy  output  1  high in any state other than S_CMD
- err  output  1  sticky: illegal command word seen; cleared only by reset

Behaviour:
- Reset (async assert, synchronous deassert release): state=S_CMD.
  - All outputs 0 (except tsi_in_ready, which follows state).
  - addr, count and data registers are 0.
- Word framing, one word per tsi_in handshake (valid && ready):
  - cmd: 0=READ, 1=WRITE.
  - addr_lo, addr_hi.
  - len_lo, len_hi: number of words minus 1.
  - WRITE only: len+1 data words follow.
- States and transitions:
  - S_CMD: accept cmd. 0→S_ADDR_LO. 1→S_ADDR_LO. Any other value → set err, stay S_CMD (word consumed).
  - S_ADDR_LO: accept word → S_ADDR_HI. S_ADDR_HI: accept word → S_LEN_LO. S_LEN_LO: accept word → S_LEN_HI.
  - S_LEN_HI: accept word, then branch on cmd. WRITE → S_WR_DATA. READ → S_RD_REQ.
  - tsi_in_ready=1 only in S_CMD..S_LEN_HI and S_WR_DATA. It is a pure function of state (no comb path from valid).
  - S_WR_DATA: accept word into wdata → S_WR_REQ.
  - S_WR_REQ: mem_req_valid=1, write=1. On mem_req_ready → S_WR_ACK.
  - S_WR_ACK: wait mem_resp_valid. Then if count==0 → S_CMD; else count−1, addr+WORD_BYTES → S_WR_DATA.
  - S_RD_REQ: mem_req_valid=1, write=0. On ready → S_RD_RESP.
  - S_RD_RESP: on mem_resp_valid capture data → S_RD_SEND.
  - S_RD_SEND: tsi_out_valid=1, tsi_out_bits=captured data (stable while stalled). On tsi_out_ready: if count==0 → S_CMD; else count−1, addr+WORD_BYTES → S_RD_REQ.
- Writes produce no TSI response.
- Registers:
  - count is 32 bits, loaded from len_lo; len_hi is ignored.
  - count=0xFFFFFFFF means 2^32 words; it must not terminate early.
- Address arithmetic: addr increments modulo 2^ADDR_W. 0xFFFFFFFC+4 → 0x00000000 at ADDR_W=32.
- One memory request outstanding at most.
  - mem_resp_valid in any state other than S_WR_ACK/S_RD_RESP is ignored.
  - A response in the same cycle as the request handshake is not legal for the memory side; it is not required to be handled.
- Request stability: mem_req_* held stable while valid && !ready.
- Minimum per-word latency:
  - WRITE: 3 cycles (accept, req, ack).
  - READ: 3 cycles (req, resp, send) given zero-wait memory and host.
- Reset mid-transfer: aborts immediately. Partial writes already issued remain; no response is owed.

Decomposition:
- Package tsi_pkg:
  - TSI_CMD_READ=0, TSI_CMD_WRITE=1.
  - tsi_state_e enum (S_CMD…S_RD_SEND).
  - TSI_WORD_W=32.
- No sub-module needed. The single FSM with address/count/data registers fits in one module.

Test Plan:
- WRITE cmd=1, addr=0x80000000, len=0, data=0xDEADBEEF → exactly one mem write addr=0x80000000 wdata=0xDEADBEEF; busy drops after ack; no tsi_out_valid.
- READ addr=0x1000, len=3, memory returns addr-based data → four reads at 0x1000,0x1004,0x1008,0x100C; tsi_out words in order; busy low after 4th handshake.
- Back-pressure: READ len=1 with tsi_out_ready low 5 cycles and mem_req_ready random → tsi_out_bits stable while stalled; no second mem request before the first word is sent.
- Wrap: WRITE addr_lo=0xFFFFFFFC, len=1 → writes to 0xFFFFFFFC then 0x00000000; addr_hi=0x1 has no effect.
- Illegal cmd=7 followed by valid READ len=0 → err=1 sticky; READ completes normally.
- Assert reset during S_WR_ACK of len=3 WRITE → all outputs 0 asynchronously; a fresh READ after release executes correctly.
